// File: rtl/moore_stream_if.sv
// Stream/detector bundle for moore_stream_ctrl: word input handshake, serial
// detector link, and match reporting.
interface moore_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             det_i;
  logic             det_o;
  logic             clear;
  logic             word_done;
  logic             match_in_word;
  logic [CNT_W-1:0] match_count;

  modport master (
    output data_in, data_valid, det_o, clear,
    input  data_ready, det_i, word_done, match_in_word, match_count
  );

  modport slave (
    input  data_in, data_valid, det_o, clear,
    output data_ready, det_i, word_done, match_in_word, match_count
  );
endinterface

// File: rtl/moore_stream_ctrl.sv
// Serializes words MSB first into an external Moore sequence detector and
// counts the detections it reports one cycle after each bit.
module moore_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  moore_stream_if.slave s
);
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  localparam int             BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]  LAST = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic             flag;
  logic             hit;

  assign sreg_nxt = sreg << 1;

  // det_o lags det_i by one cycle: the first SHIFT cycle still shows the
  // response to idle zeros, and DRAIN carries the response to the last bit.
  assign hit = s.det_o && (((state == SHIFT) && (bit_cnt != '0)) || (state == DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      sreg            <= '0;
      bit_cnt         <= '0;
      flag            <= 1'b0;
      s.det_i         <= 1'b0;
      s.data_ready    <= 1'b1;
      s.word_done     <= 1'b0;
      s.match_in_word <= 1'b0;
      s.match_count   <= '0;
    end else begin
      if (s.clear)
        s.match_count <= '0;
      else if (hit && (s.match_count != MAX))
        s.match_count <= s.match_count + 1'b1;

      s.word_done <= 1'b0;

      case (state)
        IDLE: begin
          if (s.data_valid) begin
            sreg         <= s.data_in;
            s.det_i      <= s.data_in[WIDTH-1];
            bit_cnt      <= '0;
            flag         <= 1'b0;
            s.data_ready <= 1'b0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (hit) flag <= 1'b1;
          sreg    <= sreg_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            s.det_i <= 1'b0;
            state   <= DRAIN;
          end else begin
            s.det_i <= sreg_nxt[WIDTH-1];
          end
        end
        DRAIN: begin
          // Fold in the final sample so match_in_word is valid alongside word_done.
          s.match_in_word <= flag | hit;
          s.word_done     <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          s.data_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_moore_stream_ctrl.sv
// Bench for moore_stream_ctrl with an external "1101" Moore detector (overlap),
// a phase-based reference model and directed word scenarios.
module tb_moore_stream_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  moore_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  moore_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .s(bus));

  // External Moore detector: state is the last four bits seen on det_i.
  logic [3:0] hist;
  always @(posedge clk or posedge rst)
    if (rst) hist <= 4'b0;
    else     hist <= {hist[2:0], bus.det_i};
  assign bus.det_o = (hist == 4'b1101);

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: m_ph counts cycles since the accept edge (-1 when idle).
  // Phases 0..WIDTH-1 shift, WIDTH drains, WIDTH+1 is the done pulse.
  int               m_ph = -1;
  logic [WIDTH-1:0] m_word = '0;
  bit               m_flag = 0, m_miw = 0;
  int               m_cnt = 0;
  bit               m_hit;
  int               acc_q[$];
  time              acc_t[$];

  assign m_hit = bus.det_o && (m_ph >= 1) && (m_ph <= WIDTH);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= -1;
      m_flag <= 0;
      m_miw  <= 0;
      m_cnt  <= 0;
    end else begin
      if (bus.clear) m_cnt <= 0;
      else if (m_hit && m_cnt < MAXC) m_cnt <= m_cnt + 1;
      if (m_ph == WIDTH) m_miw <= m_flag | m_hit;
      if (m_ph == WIDTH + 1) m_ph <= -1;
      else if (m_ph >= 0) begin
        m_ph <= m_ph + 1;
        if (m_hit) m_flag <= 1;
      end else if (bus.data_valid) begin
        m_ph   <= 0;
        m_word <= bus.data_in;
        m_flag <= 0;
        acc_q.push_back(int'(bus.data_in));
        acc_t.push_back($time);
      end
    end
  end

  always @(negedge clk) begin
    chk("data_ready", bus.data_ready, 32'(m_ph == -1));
    chk("det_i", bus.det_i, (m_ph >= 0 && m_ph < WIDTH) ? 32'(m_word[WIDTH-1-m_ph]) : 32'd0);
    chk("word_done", bus.word_done, 32'(m_ph == WIDTH + 1));
    chk("match_in_word", bus.match_in_word, 32'(m_miw));
    chk("match_count", bus.match_count, 32'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and return once the accept edge has passed (phase 0).
  task automatic send(input logic [WIDTH-1:0] w, input bit keep, output int waits);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    waits = 0;
    while (!bus.data_ready && waits < 40) begin
      step();
      waits++;
    end
    if (!bus.data_ready) chk("accept_timeout", 32'd0, 32'd1);
    step();
    if (!keep) bus.data_valid = 1'b0;
  endtask

  // From phase 0: collect det_i bits, then wait for word_done (ends in DONE).
  task automatic finish_word(output int lat, output logic [WIDTH-1:0] seq);
    seq = '0;
    for (int k = 0; k < WIDTH; k++) begin
      seq = {seq[WIDTH-2:0], bus.det_i};
      step();
    end
    lat = WIDTH;
    while (!bus.word_done && lat < 40) begin
      step();
      lat++;
    end
    if (!bus.word_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_word(input logic [WIDTH-1:0] w, input int exp_cnt, input bit exp_miw,
                          input string tag, output int waits);
    int lat;
    logic [WIDTH-1:0] seq;
    send(w, 1'b0, waits);
    finish_word(lat, seq);
    chk({tag, "_done_latency"}, 32'(lat + 1), 32'd10);
    chk({tag, "_det_seq"}, 32'(seq), 32'(w));
    chk({tag, "_count"}, bus.match_count, 32'(exp_cnt));
    chk({tag, "_miw"}, bus.match_in_word, 32'(exp_miw));
    step();
  endtask

  logic [WIDTH-1:0] cw [4] = '{8'hA5, 8'h3C, 8'hDD, 8'h0D};

  initial begin
    int wt, lat, n, seen;
    logic [WIDTH-1:0] seq;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.clear      = 1'b0;
    #1 rst = 1'b1;
    repeat (3) step();
    chk("rst_ready", bus.data_ready, 32'd1);
    chk("rst_det_i", bus.det_i, 32'd0);
    chk("rst_done", bus.word_done, 32'd0);
    chk("rst_miw", bus.match_in_word, 32'd0);
    chk("rst_count", bus.match_count, 32'd0);
    rst = 1'b0;

    run_word(8'hD0, 1, 1'b1, "d0", wt);
    run_word(8'hDD, 3, 1'b1, "dd", wt);
    run_word(8'h00, 3, 1'b0, "zero", wt);

    // Back-to-back words with data_valid held high; data_in moves on mid-word.
    for (int i = 0; i < 4; i++) send(cw[i], 1'b1, wt);
    bus.data_valid = 1'b0;
    finish_word(lat, seq);
    chk("stream_last_seq", 32'(seq), 32'h0D);
    chk("stream_count", bus.match_count, 32'd6);
    chk("stream_miw", bus.match_in_word, 32'd1);
    n = acc_q.size();
    for (int i = 0; i < 4; i++) chk("stream_order", 32'(acc_q[n-4+i]), 32'(cw[i]));
    for (int i = 1; i < 4; i++) chk("stream_spacing", 32'(acc_t[n-4+i] - acc_t[n-5+i]), 32'd110);
    step();

    // Clear coinciding with the DRAIN-cycle detection.
    send(8'hDD, 1'b0, wt);
    repeat (WIDTH) step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_win_count", bus.match_count, 32'd0);
    chk("clear_keeps_miw", bus.match_in_word, 32'd1);
    chk("clear_keeps_fsm", bus.word_done, 32'd1);
    step();

    // Reset during the third shift cycle.
    send(8'hD0, 1'b0, wt);
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("midrst_ready", bus.data_ready, 32'd1);
    chk("midrst_det_i", bus.det_i, 32'd0);
    chk("midrst_miw", bus.match_in_word, 32'd0);
    chk("midrst_count", bus.match_count, 32'd0);
    step();
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      step();
      if (bus.word_done) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_word(8'h0D, 1, 1'b1, "postrst", wt);
    chk("postrst_first_accept", 32'(wt), 32'd0);

    // Saturation: 255 matching words, then one more.
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("sat_cleared", bus.match_count, 32'd0);
    for (int i = 0; i < MAXC; i++) send(8'hD0, 1'b1, wt);
    bus.data_valid = 1'b0;
    finish_word(lat, seq);
    chk("sat_preload", bus.match_count, 32'd255);
    step();
    run_word(8'hD0, 255, 1'b1, "sat", wt);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
